cic_decim_strobed: RTL and testbench

//  Receive-side counterpart of the strobed CIC interpolator: a self-timed
//  CIC decimator with an integrated programmable rate counter.
//  - Takes one signed ADC-width sample per clk_120mhz cycle.
//  - Decimates by a run-time rate.
//  - Normalises the CIC gain and emits OUT_WIDTH samples with a one-cycle

---
 rtl/cic_decim_strobed.sv | 102 ++++++++++
 tb/tb_cic_decim_strobed.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cic_decim_strobed.sv
// rtl/cic_decim_strobed.sv - self-timed CIC decimator with programmable rate counter
// and gain normalisation to OUT_WIDTH.
module cic_decim_strobed #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 16,
  parameter int STAGES    = 4,
  parameter int MAX_RATE  = 128,
  parameter int ACC_WIDTH = 40
) (
  input  logic                        clk_120mhz,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [7:0]                  rate,
  input  logic signed [IN_WIDTH-1:0]  signal_in,
  output logic signed [OUT_WIDTH-1:0] signal_out,
  output logic                        strobe_out
);

  localparam int GROW = OUT_WIDTH - IN_WIDTH;
  localparam int YW   = ACC_WIDTH + GROW;

  logic [7:0] counter;
  logic [7:0] shift_q;
  logic [7:0] eff_rate;
  logic [7:0] shift_next;
  logic       strobe;

  logic signed [ACC_WIDTH-1:0] integ   [STAGES];
  logic signed [ACC_WIDTH-1:0] dly     [STAGES];
  logic signed [ACC_WIDTH-1:0] comb_in [STAGES];
  logic signed [ACC_WIDTH-1:0] comb_acc;
  logic signed [YW-1:0]        c_ext;
  logic signed [YW-1:0]        y_wide;
  logic signed [OUT_WIDTH-1:0] y;

  function automatic int clog2_rt(input logic [7:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if ((9'd1 << i) < {1'b0, v}) r = i + 1;
    end
    return r;
  endfunction

  always_comb begin
    eff_rate = rate;
    if (rate == 8'd0) eff_rate = 8'd1;
    else if (int'(rate) > MAX_RATE) eff_rate = 8'(MAX_RATE);
    shift_next = 8'(STAGES * clog2_rt(eff_rate));
  end

  assign strobe = (counter == 8'd0);

  // Comb chain evaluated combinationally; comb_in[k] is what d[k] captures.
  always_comb begin
    comb_acc = integ[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      comb_in[k] = comb_acc;
      comb_acc   = comb_acc - dly[k];
    end
  end

  // shift_q belongs to the period that ends at this strobe, not the next one.
  always_comb begin
    c_ext = YW'(comb_acc);
    if (int'(shift_q) >= GROW) y_wide = c_ext >>> (int'(shift_q) - GROW);
    else                       y_wide = c_ext <<< (GROW - int'(shift_q));
    if ((&y_wide[YW-1:OUT_WIDTH-1]) || ~(|y_wide[YW-1:OUT_WIDTH-1]))
      y = y_wide[OUT_WIDTH-1:0];
    else if (y_wide[YW-1])
      y = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      y = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk_120mhz) begin
    if (reset || !enable) begin
      counter    <= 8'd0;
      shift_q    <= 8'd0;
      signal_out <= '0;
      strobe_out <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
      end
    end else begin
      integ[0] <= integ[0] + ACC_WIDTH'(signal_in);
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
      strobe_out <= 1'b0;
      if (strobe) begin
        counter    <= eff_rate - 8'd1;
        shift_q    <= shift_next;
        signal_out <= y;
        strobe_out <= 1'b1;
        for (int k = 0; k < STAGES; k++) dly[k] <= comb_in[k];
      end else begin
        counter <= counter - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_strobed.sv
// tb/tb_cic_decim_strobed.sv - directed DC vectors, multi-cycle corner sequences and
// random input against a boxcar-convolution model of the CIC decimator.
module tb_cic_decim_strobed;

  logic               clk_120mhz = 1'b0;
  logic               reset;
  logic               enable;
  logic [7:0]         rate;
  logic signed [11:0] signal_in;
  logic signed [15:0] signal_out;
  logic               strobe_out;

  int vectors = 0;
  int miscompares = 0;

  cic_decim_strobed dut (
    .clk_120mhz(clk_120mhz),
    .reset(reset),
    .enable(enable),
    .rate(rate),
    .signal_in(signal_in),
    .signal_out(signal_out),
    .strobe_out(strobe_out)
  );

  always #4 clk_120mhz = ~clk_120mhz;

  typedef struct {
    int rate_in;
    int din;
    int exp_out;
    int period;
  } dc_vec_t;

  dc_vec_t vecs[11];

  longint h[0:1023];
  int     hl;
  int     xs[0:1023];

  task automatic tick();
    @(posedge clk_120mhz);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Impulse response of STAGES cascaded length-r boxcars.
  task automatic build_h(input int r);
    longint t[0:1023];
    hl = 1;
    h[0] = 1;
    repeat (4) begin
      for (int i = 0; i < hl + r - 1; i++) t[i] = 0;
      for (int i = 0; i < hl; i++)
        for (int j = 0; j < r; j++) t[i+j] += h[i];
      hl = hl + r - 1;
      for (int i = 0; i < hl; i++) h[i] = t[i];
    end
  endtask

  function automatic longint model_y(input int r, input int n);
    longint c, y;
    int sh;
    c = 0;
    for (int m = 0; m < hl; m++)
      if (n - 4 - m >= 0) c += h[m] * longint'(xs[n-4-m]);
    sh = 4 * $clog2(r);
    if (sh >= 4) y = c >>> (sh - 4);
    else         y = c <<< (4 - sh);
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic run_vec(input int idx);
    dc_vec_t v;
    int p;
    v = vecs[idx];
    p = v.period;
    reset = 1'b1;
    enable = 1'b1;
    rate = 8'(v.rate_in);
    signal_in = 12'(v.din);
    tick();
    reset = 1'b0;
    for (int n = 0; n < 8 * p; n++) begin
      tick();
      chk($sformatf("vec%0d strobe n=%0d", idx, n), longint'(strobe_out), longint'(n % p == 0));
      if (n % p == 0 && n / p >= 4)
        chk($sformatf("vec%0d out n=%0d", idx, n), longint'(signal_out), longint'(v.exp_out));
    end
  endtask

  task automatic run_model(input int r, input int ncyc, input bit use_reset);
    int x;
    build_h(r);
    rate = 8'(r);
    if (use_reset) reset = 1'b1;
    else           enable = 1'b0;
    tick();
    chk($sformatf("clear r=%0d strobe", r), longint'(strobe_out), 0);
    chk($sformatf("clear r=%0d out", r), longint'(signal_out), 0);
    reset = 1'b0;
    enable = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      x = int'($urandom_range(4095)) - 2048;
      xs[n] = x;
      signal_in = 12'(x);
      tick();
      chk($sformatf("rand r=%0d strobe n=%0d", r, n), longint'(strobe_out), longint'(n % r == 0));
      if (n % r == 0)
        chk($sformatf("rand r=%0d out n=%0d", r, n), longint'(signal_out), model_y(r, n));
    end
  endtask

  initial begin
    vecs[0]  = '{32, 1, 16, 32};
    vecs[1]  = '{32, 2047, 32752, 32};
    vecs[2]  = '{32, -2048, -32768, 32};
    vecs[3]  = '{3, 1024, 5184, 3};
    vecs[4]  = '{1, -5, -80, 1};
    vecs[5]  = '{0, -5, -80, 1};
    vecs[6]  = '{200, 3, 48, 128};
    vecs[7]  = '{5, 100, 244, 5};
    vecs[8]  = '{5, -100, -245, 5};
    vecs[9]  = '{128, 2047, 32752, 128};
    vecs[10] = '{2, -7, -112, 2};

    reset = 1'b1;
    enable = 1'b0;
    rate = 8'd32;
    signal_in = '0;
    tick();
    tick();
    chk("reset strobe_out", longint'(strobe_out), 0);
    chk("reset signal_out", longint'(signal_out), 0);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Rate change 32 -> 8 in the middle of the second 32-cycle period.
    reset = 1'b1;
    enable = 1'b1;
    rate = 8'd32;
    signal_in = 12'sd1;
    tick();
    reset = 1'b0;
    for (int n = 0; n <= 104; n++) begin
      tick();
      if (n == 40) rate = 8'd8;
      chk($sformatf("ratechg strobe n=%0d", n), longint'(strobe_out),
          longint'(n == 0 || n == 32 || (n >= 64 && n % 8 == 0)));
      if (n == 96 || n == 104)
        chk($sformatf("ratechg out n=%0d", n), longint'(signal_out), 16);
    end

    // Each run starts with a one-cycle clear while the previous one is mid-period.
    run_model(2, 200, 1'b1);
    run_model(5, 300, 1'b0);
    run_model(64, 700, 1'b1);
    run_model(128, 700, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
